// File: rtl/tmds_channel_encoder_if.sv
// Pixel-side bundle of one TMDS channel encoder: component data, data enable,
// control bits in, 10-bit symbol out towards the serializer.
interface tmds_channel_encoder_if;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic [9:0] sym_out;

    modport master (output de, data, ctrl, input sym_out);
    modport slave  (input de, data, ctrl, output sym_out);
endinterface

// File: rtl/tmds_channel_encoder.sv
// One TMDS channel encoder (8b/10b transition-minimised, DC-balanced).
// Stage 1 builds q_m from the pixel component; stage 2 applies the running
// disparity and emits one 10-bit symbol per pixel clock.
// Optional macro TMDS_ENCODER_PIPE_EN registers q_m/de/ctrl between the two
// stages (latency 2 instead of 1, identical symbols).
module tmds_channel_encoder (
    input  logic                   clk_in,
    input  logic                   rst_in,
    tmds_channel_encoder_if.slave  bus
);
    localparam logic [9:0] CTRL_00 = 10'h354;
    localparam logic [9:0] CTRL_01 = 10'h0AB;
    localparam logic [9:0] CTRL_10 = 10'h154;
    localparam logic [9:0] CTRL_11 = 10'h2AB;

    logic [3:0] n1d;
    logic       use_xnor;
    logic [8:0] q_m;

    logic [8:0] s2_qm;
    logic       s2_de;
    logic [1:0] s2_ctrl;

    logic [3:0]        n1;
    logic signed [4:0] diff;     // n1 - n0 of q_m[7:0]
    logic signed [4:0] cnt_q;
    logic signed [4:0] cnt_nxt;
    logic [9:0]        sym_q;
    logic [9:0]        sym_nxt;

    // Stage 1: ones count of the component and XOR/XNOR chain selection
    always_comb begin
        n1d = '0;
        for (int i = 0; i < 8; i++)
            n1d = n1d + {3'b000, bus.data[i]};
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !bus.data[0]);
    end

    // Stage 1: transition-minimised word, bit 8 flags XOR (1) vs XNOR (0)
    always_comb begin
        q_m    = '0;
        q_m[0] = bus.data[0];
        for (int i = 1; i < 8; i++)
            q_m[i] = use_xnor ? ~(q_m[i-1] ^ bus.data[i]) : (q_m[i-1] ^ bus.data[i]);
        q_m[8] = ~use_xnor;
    end

`ifdef TMDS_ENCODER_PIPE_EN
    // Stage boundary register; reset flushes in-flight data as a control 00 slot
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s2_qm   <= '0;
            s2_de   <= 1'b0;
            s2_ctrl <= 2'b00;
        end else begin
            s2_qm   <= q_m;
            s2_de   <= bus.de;
            s2_ctrl <= bus.ctrl;
        end
    end
`else
    assign s2_qm   = q_m;
    assign s2_de   = bus.de;
    assign s2_ctrl = bus.ctrl;
`endif

    // Stage 2: ones count of q_m[7:0] and its signed imbalance
    always_comb begin
        n1 = '0;
        for (int i = 0; i < 8; i++)
            n1 = n1 + {3'b000, s2_qm[i]};
        // 2*n1 - 8 in 5-bit modular arithmetic; n1=8 wraps through -16 to +8
        diff = $signed({n1, 1'b0}) - 5'sd8;
    end

    // Stage 2: symbol selection and next running disparity
    always_comb begin
        sym_nxt = CTRL_00;
        cnt_nxt = cnt_q;
        if (!s2_de) begin
            case (s2_ctrl)
                2'b00:   sym_nxt = CTRL_00;
                2'b01:   sym_nxt = CTRL_01;
                2'b10:   sym_nxt = CTRL_10;
                default: sym_nxt = CTRL_11;
            endcase
            cnt_nxt = 5'sd0;
        end else if ((cnt_q == 5'sd0) || (diff == 5'sd0)) begin
            sym_nxt = {~s2_qm[8], s2_qm[8], s2_qm[8] ? s2_qm[7:0] : ~s2_qm[7:0]};
            cnt_nxt = s2_qm[8] ? (cnt_q + diff) : (cnt_q - diff);
        end else if ((!cnt_q[4] && (diff > 5'sd0)) || (cnt_q[4] && (diff < 5'sd0))) begin
            // disparity and word lean the same way: invert to pull back
            sym_nxt = {1'b1, s2_qm[8], ~s2_qm[7:0]};
            cnt_nxt = cnt_q + $signed({3'b000, s2_qm[8], 1'b0}) - diff;
        end else begin
            sym_nxt = {1'b0, s2_qm[8], s2_qm[7:0]};
            cnt_nxt = cnt_q + diff - $signed({3'b000, ~s2_qm[8], 1'b0});
        end
    end

    // Output symbol and disparity registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sym_q <= CTRL_00;
            cnt_q <= 5'sd0;
        end else begin
            sym_q <= sym_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    assign bus.sym_out = sym_q;
endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Bench for tmds_channel_encoder: directed literal sequences, a reduced
// 800-column timing frame with colour bars and noise, a mid-line reset and a
// random segment, all checked cycle by cycle against a behavioural model,
// a symbol decoder and a running-disparity bound.
module tb_tmds_channel_encoder;
`ifdef TMDS_ENCODER_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [9:0] sym;
        bit         de;
        logic [7:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    tmds_channel_encoder_if bus_if ();

    tmds_channel_encoder dut (.clk_in(clk), .rst_in(rst), .bus(bus_if));

    always #20 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_cnt = 0;
    bit   started = 1'b0;
    ent_t exp_e;
    ent_t mq[$];
    int   m_cnt = 0;
    logic [9:0] hist [0:4095];

    bit         sd_de   [8];
    logic [7:0] sd_data [8];
    logic [1:0] sd_ctrl [8];
    logic [9:0] sd_exp  [8];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    // Reference encoder: spec rules in plain integer arithmetic
    task automatic model_enc(input bit de, input bit [7:0] d, input bit [1:0] c,
                             inout int cnt, output bit [9:0] s);
        bit [8:0] qm;
        int n1d, n1, df;
        bit xn;
        if (!de) begin
            case (c)
                2'b00: s = 10'h354;
                2'b01: s = 10'h0AB;
                2'b10: s = 10'h154;
                default: s = 10'h2AB;
            endcase
            cnt = 0;
            return;
        end
        n1d = $countones(d);
        xn = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xn;
        n1 = $countones(qm[7:0]);
        df = n1 - (8 - n1);
        if (cnt == 0 || df == 0) begin
            s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cnt += qm[8] ? df : -df;
        end else if ((cnt > 0 && df > 0) || (cnt < 0 && df < 0)) begin
            s = {1'b1, qm[8], ~qm[7:0]};
            cnt += 2 * int'(qm[8]) - df;
        end else begin
            s = {1'b0, qm[8], qm[7:0]};
            cnt += df - 2 * (1 - int'(qm[8]));
        end
    endtask

    // Inverse of the TMDS data coding, recovers the pixel component
    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] d, q;
        d = s[9] ? ~s[7:0] : s[7:0];
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return q;
    endfunction

    // Model: advance once per active edge, delay results by the latency
    initial begin
        ent_t e;
        bit [9:0] s;
        forever begin
            @(posedge clk);
            edge_cnt++;
            if (rst) begin
                started = 1'b1;
                m_cnt = 0;
                mq.delete();
                e.sym = 10'h354; e.de = 1'b0; e.data = 8'h00;
                for (int i = 0; i < LAT - 1; i++) mq.push_back(e);
                exp_e = e;
            end else if (started) begin
                model_enc(bus_if.de, bus_if.data, bus_if.ctrl, m_cnt, s);
                check("model_cnt_bound", 32'(m_cnt >= -10 && m_cnt <= 10), 32'd1);
                e.sym = s; e.de = bus_if.de; e.data = bus_if.data;
                mq.push_back(e);
                exp_e = mq.pop_front();
            end
        end
    end

    // Compare: every cycle on the falling edge
    initial begin
        int run = 0;
        forever begin
            @(negedge clk);
            if (edge_cnt < 4096) hist[edge_cnt] = bus_if.sym_out;
            if (started) begin
                check("sym_vs_model", 32'(bus_if.sym_out), 32'(exp_e.sym));
                if (exp_e.de) begin
                    check("decode", 32'(decode(bus_if.sym_out)), 32'(exp_e.data));
                    run += 2 * $countones(bus_if.sym_out) - 10;
                    check("disparity_bound", 32'(run >= -10 && run <= 10), 32'd1);
                end else begin
                    run = 0;
                end
            end
        end
    end

    task automatic step(input bit d, input logic [7:0] v, input logic [1:0] c);
        bus_if.de = d; bus_if.data = v; bus_if.ctrl = c;
        @(posedge clk);
        #1;
    endtask

    // Apply sd_* for n cycles, flush with control, check literal outputs
    task automatic seq_check(input string nm, input int n);
        int e0;
        e0 = edge_cnt;
        for (int k = 0; k < n; k++) step(sd_de[k], sd_data[k], sd_ctrl[k]);
        for (int k = 0; k < LAT + 1; k++) step(1'b0, 8'h00, 2'b00);
        @(negedge clk);
        #1;
        for (int k = 0; k < n; k++) check(nm, 32'(hist[e0 + k + LAT]), 32'(sd_exp[k]));
    endtask

    localparam logic [7:0] BARS [8] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};

    initial begin
        int c;
        bit [9:0] s;
        bit de;
        logic [7:0] v;
        logic [1:0] ct;

        // Model pinned against hand-derived symbols
        c = 0;  model_enc(1'b1, 8'h00, 2'b00, c, s); check("pin_00_a", 32'(s), 32'h100); check("pin_cnt_a", 32'(c), 32'(-8));
        model_enc(1'b1, 8'h00, 2'b00, c, s); check("pin_00_b", 32'(s), 32'h3FF); check("pin_cnt_b", 32'(c), 32'd2);
        model_enc(1'b1, 8'h00, 2'b00, c, s); check("pin_00_c", 32'(s), 32'h100); check("pin_cnt_c", 32'(c), 32'(-6));
        c = 0;  model_enc(1'b1, 8'hFF, 2'b00, c, s); check("pin_ff", 32'(s), 32'h200); check("pin_cnt_ff", 32'(c), 32'(-8));

        // Reset held 3 clocks with active data present
        rst = 1'b1; bus_if.de = 1'b1; bus_if.data = 8'hA5; bus_if.ctrl = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("reset_sym", 32'(bus_if.sym_out), 32'h354);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 2'b00);

        // Control codes in order
        sd_de = '{0,0,0,0,0,0,0,0}; sd_data = '{default: 8'h00};
        sd_ctrl = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        sd_exp  = '{10'h354, 10'h0AB, 10'h154, 10'h2AB, 10'h354, 10'h354, 10'h354, 10'h354};
        seq_check("ctrl_codes", 4);

        // Disparity walk on zeros from cnt=0
        sd_de = '{1,1,1,0,0,0,0,0}; sd_ctrl = '{default: 2'b00};
        sd_exp = '{10'h100, 10'h3FF, 10'h100, 10'h354, 10'h354, 10'h354, 10'h354, 10'h354};
        seq_check("disparity_seq", 3);

        // XNOR path
        sd_de = '{1,0,0,0,0,0,0,0}; sd_data = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        sd_exp = '{10'h200, 10'h354, 10'h354, 10'h354, 10'h354, 10'h354, 10'h354, 10'h354};
        seq_check("xnor_ff", 1);

        // Disparity cleared by a single control slot
        sd_de = '{1,0,1,0,0,0,0,0}; sd_data = '{default: 8'h00};
        sd_exp = '{10'h100, 10'h354, 10'h100, 10'h354, 10'h354, 10'h354, 10'h354, 10'h354};
        seq_check("disparity_clear", 3);

        // Reduced frame: 800 columns x 60 lines, blue-channel syncs, noisy bars
        for (int line = 0; line < 60; line++) begin
            for (int col = 0; col < 800; col++) begin
                de = (col < 640) && (line < 48);
                ct = {~(line >= 50 && line < 52), ~(col >= 656 && col < 752)};
                v  = BARS[col / 80];
                if ($urandom_range(0, 3) == 0) v = 8'($urandom);
                rst = (line == 30 && col == 300);
                step(de, v, ct);
            end
        end
        rst = 1'b0;

        // Fully random segment
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 5) != 0, 8'($urandom), 2'($urandom));
        for (int i = 0; i < LAT + 2; i++) step(1'b0, 8'h00, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
